fetch_arbiter: RTL and testbench
================================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 SHALL have parameter NWAY, default 2: number of fetch ways sharing one instruction-memory port, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: instruction address width.
REQ-003 SHALL have parameter INST_W, default 32: instruction word width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port request_i, input, NWAY: per-way fetch request, level, held until that way's dataOk_o.
REQ-007 SHALL have port instAddr_i, input, NWAY*ADDR_W: per-way fetch address, way w in bits [w*ADDR_W +: ADDR_W], stable while request_i[w] is high.
REQ-008 SHALL have port flush_i, input, NWAY: per-way jump/flush pulse; cancels that way's fetch.
REQ-009 SHALL have port dataOk_o, output, NWAY: per-way one-cycle response-valid pulse.
REQ-010 SHALL have port inst_o, output, NWAY*INST_W: per-way instruction word, valid when dataOk_o[w] is high, held afterwards.
REQ-011 SHALL have port mem_request_o, output, 1: memory request, held until mem_dataOk_i.
REQ-012 SHALL have port mem_instAddr_o, output, ADDR_W: memory address, stable while mem_request_o is high.
REQ-013 SHALL have port mem_inst_i, input, INST_W: memory read data, valid with mem_dataOk_i.
REQ-014 SHALL have port mem_dataOk_i, input, 1: memory response strobe.
REQ-015 SHALL have port grantId_o, output, $clog2(NWAY): way currently owning the memory port.
REQ-016 SHALL have port busy_o, output, 1: high when the FSM is not IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; only one memory transaction is outstanding at a time.
REQ-018 In IDLE with any request_i set, SHALL grant round-robin starting at rrPtr, latch the way id and address, and enter WAIT; mem_request_o rises on the next cycle.
REQ-019 On each grant, rrPtr SHALL become (granted+1) mod NWAY, so a continuously requesting way waits at most NWAY-1 grants.
REQ-020 In WAIT, mem_request_o SHALL stay high and mem_instAddr_o SHALL stay constant until mem_dataOk_i; the same edge drops mem_request_o and enters RESP.
REQ-021 In RESP, for the granted way, SHALL assert dataOk_o for exactly one cycle and capture mem_inst_i into inst_o, unless the drop flag is set; requests SHALL be ignored in RESP.
REQ-022 Latency: mem_dataOk_i in cycle k SHALL give dataOk_o in cycle k+1; an idle grant in cycle 0 SHALL give mem_request_o in cycle 1.
REQ-023 flush_i[g] during WAIT for the granted way g SHALL set a drop flag; the memory response is consumed, no dataOk_o is produced, and inst_o is unchanged.
REQ-024 flush_i[g] in the same cycle as mem_dataOk_i SHALL also drop the response.
REQ-025 flush_i on a non-granted way, or in IDLE, SHALL have no effect.
REQ-026 A request_i that is deasserted while in WAIT SHALL be treated like a flush of that way.
REQ-027 grantId_o SHALL hold its last value in IDLE.

Reset
REQ-028 Reset SHALL force state IDLE, rrPtr=0, drop flag=0, mem_request_o=0, mem_instAddr_o=0, dataOk_o=0, inst_o=0, grantId_o=0, busy_o=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; a mem_dataOk_i arriving later while in IDLE SHALL be ignored.

Structure
REQ-030 A shared package fetch_arb_pkg SHALL hold the FSM state encoding and the default values of NWAY, ADDR_W and INST_W.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and rrPtr; outputs: grant valid and index).

Verification
REQ-032 Single request: way0 requests addr 0x80000000; memory answers 0x00000013 after 3 cycles -> mem_request_o in cycle 1, dataOk_o[0] one cycle after mem_dataOk_i, inst_o[0]=0x00000013.
REQ-033 Contention, NWAY=2: both ways request continuously from reset -> grants alternate 0,1,0,1 over 4 transactions, and each dataOk_o goes only to its granted way.
REQ-034 Flush: flush_i[1] pulses 1 cycle after way1's grant -> no dataOk_o[1], inst_o[1] unchanged, FSM returns to IDLE after mem_dataOk_i.
REQ-035 Reset mid-WAIT: reset_n low for 2 cycles, then a stale mem_dataOk_i -> all outputs 0, no dataOk_o, rrPtr=0.
REQ-036 NWAY=4 fairness: ways 0, 2 and 3 request continuously -> grant order 0,2,3,0,2,3, and no way waits more than 3 grants.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_arb_pkg
//  Purpose  : Shared types and default sizes for the instruction-fetch
//             arbiter (state encoding, default way count and widths).
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_arb_pkg;

    // Default sizing of the arbiter
    localparam int DEF_NWAY   = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;

    // Arbiter FSM: one outstanding memory transaction at a time
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for any way to request
        ST_WAIT = 2'd1,   // memory request issued, waiting for response
        ST_RESP = 2'd2    // response delivered (or dropped) this cycle
    } arb_state_t;

endpackage : fetch_arb_pkg
`default_nettype wire

// File: rtl/fetch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first requesting
//             way found when scanning upward (with wrap) from i_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fetch_arb_pkg::*;
#(
    parameter int NWAY  = DEF_NWAY,
    parameter int GID_W = $clog2(NWAY)
) (
    input  logic [NWAY-1:0]  i_req,
    input  logic [GID_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [GID_W-1:0] o_idx
);

    // Pick the requester with the smallest circular distance from i_ptr
    always_comb begin
        int w_off;
        int w_best_off;
        o_valid    = 1'b0;
        o_idx      = '0;
        w_off      = 0;
        w_best_off = NWAY;
        for (int w = 0; w < NWAY; w++) begin
            w_off = w - int'(i_ptr);
            if (w_off < 0) begin
                w_off = w_off + NWAY;
            end
            if (i_req[w] && (w_off < w_best_off)) begin
                w_best_off = w_off;
                o_valid    = 1'b1;
                o_idx      = GID_W'(w);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_arbiter
//  Purpose  : Shares one instruction-memory port between NWAY fetch ways.
//             Round-robin grant, single outstanding transaction, per-way
//             flush that silently consumes an in-flight response.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int NWAY   = DEF_NWAY,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NWAY-1:0]           request_i,
    input  logic [NWAY*ADDR_W-1:0]    instAddr_i,
    input  logic [NWAY-1:0]           flush_i,
    output logic [NWAY-1:0]           dataOk_o,
    output logic [NWAY*INST_W-1:0]    inst_o,
    output logic                      mem_request_o,
    output logic [ADDR_W-1:0]         mem_instAddr_o,
    input  logic [INST_W-1:0]         mem_inst_i,
    input  logic                      mem_dataOk_i,
    output logic [$clog2(NWAY)-1:0]   grantId_o,
    output logic                      busy_o
);

    localparam int GID_W = $clog2(NWAY);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_t             r_state;
    logic [GID_W-1:0]       r_rr_ptr;
    logic [GID_W-1:0]       r_grant;
    logic                   r_drop;
    logic                   r_mem_req;
    logic [ADDR_W-1:0]      r_addr;
    logic [NWAY-1:0]        r_data_ok;
    logic [NWAY*INST_W-1:0] r_inst;
    logic                   r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   w_pick_valid;
    logic [GID_W-1:0]       w_pick_idx;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic                   w_gnt_req;
    logic                   w_gnt_flush;
    logic                   w_cancel;
    logic [GID_W-1:0]       w_next_ptr;

    rr_pick #(
        .NWAY    (NWAY),
        .GID_W   (GID_W)
    ) u_rr_pick (
        .i_req   (request_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Address of the way the picker selects, latched on grant
    always_comb begin
        w_sel_addr = '0;
        for (int w = 0; w < NWAY; w++) begin
            if (w_pick_idx == GID_W'(w)) begin
                w_sel_addr = instAddr_i[w*ADDR_W +: ADDR_W];
            end
        end
    end

    // Request and flush of the way that currently owns the memory port
    always_comb begin
        w_gnt_req   = 1'b0;
        w_gnt_flush = 1'b0;
        for (int w = 0; w < NWAY; w++) begin
            if (r_grant == GID_W'(w)) begin
                w_gnt_req   = request_i[w];
                w_gnt_flush = flush_i[w];
            end
        end
    end

    // A dropped request is treated exactly like a flush of the owner
    assign w_cancel = w_gnt_flush | ~w_gnt_req;

    // Pointer advances past the granted way so it goes last next round
    assign w_next_ptr = (w_pick_idx == GID_W'(NWAY - 1)) ? '0
                                                         : (w_pick_idx + 1'b1);

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_drop    <= 1'b0;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_data_ok <= '0;
            r_inst    <= '0;
            r_busy    <= 1'b0;
        end else begin
            // dataOk is a single-cycle pulse unless re-armed below
            r_data_ok <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_idx;
                        r_addr    <= w_sel_addr;
                        r_rr_ptr  <= w_next_ptr;
                        r_drop    <= 1'b0;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_cancel) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_dataOk_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        // A cancel in the response cycle itself also drops it
                        if (!(r_drop || w_cancel)) begin
                            for (int w = 0; w < NWAY; w++) begin
                                if (r_grant == GID_W'(w)) begin
                                    r_data_ok[w]                <= 1'b1;
                                    r_inst[w*INST_W +: INST_W] <= mem_inst_i;
                                end
                            end
                        end
                    end
                end
                ST_RESP: begin
                    // Requests are not considered while the response is out
                    r_drop  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_drop    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign dataOk_o       = r_data_ok;
    assign inst_o         = r_inst;
    assign mem_request_o  = r_mem_req;
    assign mem_instAddr_o = r_addr;
    assign grantId_o      = r_grant;
    assign busy_o         = r_busy;

endmodule : fetch_arbiter
`default_nettype wire

// File: tb/tb_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_arbiter
//  Purpose  : Directed self-checking bench for fetch_arbiter (NWAY=2 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;
    localparam logic [31:0] A2 = 32'h8000_2000;
    localparam logic [31:0] A3 = 32'h8000_3000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // NWAY = 2 instance
    logic [1:0]  req2, flush2, ok2;
    logic [63:0] addr2, inst2;
    logic        mreq2, mok2, gid2, busy2;
    logic [31:0] maddr2, minst2;

    // NWAY = 4 instance
    logic [3:0]   req4, flush4, ok4;
    logic [127:0] addr4, inst4;
    logic         mreq4, mok4, busy4;
    logic [1:0]   gid4;
    logic [31:0]  maddr4, minst4;

    int n_cmp = 0;
    int n_err = 0;

    fetch_arbiter #(.NWAY(2), .ADDR_W(32), .INST_W(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .request_i(req2), .instAddr_i(addr2),
        .flush_i(flush2), .dataOk_o(ok2), .inst_o(inst2),
        .mem_request_o(mreq2), .mem_instAddr_o(maddr2), .mem_inst_i(minst2),
        .mem_dataOk_i(mok2), .grantId_o(gid2), .busy_o(busy2)
    );

    fetch_arbiter #(.NWAY(4), .ADDR_W(32), .INST_W(32)) dut4 (
        .clk(clk), .reset_n(reset_n), .request_i(req4), .instAddr_i(addr4),
        .flush_i(flush4), .dataOk_o(ok4), .inst_o(inst4),
        .mem_request_o(mreq4), .mem_instAddr_o(maddr4), .mem_inst_i(minst4),
        .mem_dataOk_i(mok4), .grantId_o(gid4), .busy_o(busy4)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req2 = '0; flush2 = '0; addr2 = {A1, A0}; mok2 = 1'b0; minst2 = '0;
        req4 = '0; flush4 = '0; addr4 = {A3, A2, A1, A0}; mok4 = 1'b0; minst4 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ok2, mreq2, gid2, busy2} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl2: got %b want 00000", {ok2, mreq2, gid2, busy2});
        end
        n_cmp++;
        if (inst2 !== 64'h0 || maddr2 !== 32'h0) begin
            n_err++; $display("FAIL reset_data2: inst=%h addr=%h want 0", inst2, maddr2);
        end
        n_cmp++;
        if ({ok4, mreq4, gid4, busy4} !== 8'b0 || inst4 !== 128'h0 || maddr4 !== 32'h0) begin
            n_err++; $display("FAIL reset_dut4: ctrl=%b inst=%h addr=%h want 0",
                              {ok4, mreq4, gid4, busy4}, inst4, maddr4);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy2 !== 1'b0 || mreq2 !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy=%b mreq=%b want 0 0", busy2, mreq2);
        end
    endtask

    task automatic test_single();
        req2 = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (mreq2 !== 1'b1 || maddr2 !== A0 || gid2 !== 1'b0 || busy2 !== 1'b1) begin
            n_err++; $display("FAIL single_issue: mreq=%b addr=%h gid=%b busy=%b want 1 %h 0 1",
                              mreq2, maddr2, gid2, busy2, A0);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mreq2 !== 1'b1 || maddr2 !== A0 || ok2 !== 2'b00) begin
            n_err++; $display("FAIL single_hold: mreq=%b addr=%h ok=%b want 1 %h 00", mreq2, maddr2, ok2, A0);
        end
        mok2 = 1'b1; minst2 = 32'h0000_0013;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b01 || inst2[31:0] !== 32'h0000_0013 || mreq2 !== 1'b0) begin
            n_err++; $display("FAIL single_resp: ok=%b inst0=%h mreq=%b want 01 00000013 0",
                              ok2, inst2[31:0], mreq2);
        end
        mok2 = 1'b0; minst2 = '0; req2 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b00 || busy2 !== 1'b0 || gid2 !== 1'b0 || inst2[31:0] !== 32'h0000_0013) begin
            n_err++; $display("FAIL single_after: ok=%b busy=%b gid=%b inst0=%h want 00 0 0 00000013",
                              ok2, busy2, gid2, inst2[31:0]);
        end
    endtask

    task automatic test_contention();
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        req2 = 2'b11;
        for (int t = 0; t < 4; t++) begin
            int k;
            int e;
            logic [31:0] ea;
            e  = t % 2;
            ea = (e == 1) ? A1 : A0;
            k  = 0;
            while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            n_cmp++;
            if (mreq2 !== 1'b1 || gid2 !== e[0] || maddr2 !== ea) begin
                n_err++; $display("FAIL contention_grant%0d: mreq=%b gid=%b addr=%h want 1 %0d %h",
                                  t, mreq2, gid2, maddr2, e, ea);
            end
            @(negedge clk);
            mok2 = 1'b1; minst2 = 32'h100 + t;
            @(negedge clk);
            n_cmp++;
            if (ok2 !== (2'b01 << e) || inst2[e*32 +: 32] !== 32'h100 + t) begin
                n_err++; $display("FAIL contention_resp%0d: ok=%b inst=%h want %b %h",
                                  t, ok2, inst2[e*32 +: 32], 2'b01 << e, 32'h100 + t);
            end
            mok2 = 1'b0;
            if (t == 3) req2 = 2'b00;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        int k;
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        // Way1 transaction with a flush on the non-owning way0
        req2 = 2'b10; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (mreq2 !== 1'b1 || gid2 !== 1'b1) begin
            n_err++; $display("FAIL flush_grant1: mreq=%b gid=%b want 1 1", mreq2, gid2);
        end
        flush2 = 2'b01; @(negedge clk); flush2 = 2'b00;
        mok2 = 1'b1; minst2 = 32'h1111_1111;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b10 || inst2[63:32] !== 32'h1111_1111) begin
            n_err++; $display("FAIL flush_other_way: ok=%b inst1=%h want 10 11111111", ok2, inst2[63:32]);
        end
        mok2 = 1'b0; req2 = 2'b00; @(negedge clk);
        // Flush one cycle after the grant
        req2 = 2'b10; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        flush2 = 2'b10; @(negedge clk); flush2 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (mreq2 !== 1'b1 || busy2 !== 1'b1) begin
            n_err++; $display("FAIL flush_wait_held: mreq=%b busy=%b want 1 1", mreq2, busy2);
        end
        mok2 = 1'b1; minst2 = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b00 || inst2[63:32] !== 32'h1111_1111 || mreq2 !== 1'b0) begin
            n_err++; $display("FAIL flush_drop: ok=%b inst1=%h mreq=%b want 00 11111111 0",
                              ok2, inst2[63:32], mreq2);
        end
        mok2 = 1'b0; req2 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (busy2 !== 1'b0 || ok2 !== 2'b00) begin
            n_err++; $display("FAIL flush_idle: busy=%b ok=%b want 0 00", busy2, ok2);
        end
        // Flush coinciding with the memory response
        req2 = 2'b10; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        flush2 = 2'b10; mok2 = 1'b1; minst2 = 32'h2222_2222;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b00 || inst2[63:32] !== 32'h1111_1111) begin
            n_err++; $display("FAIL flush_same_cycle: ok=%b inst1=%h want 00 11111111", ok2, inst2[63:32]);
        end
        flush2 = 2'b00; mok2 = 1'b0; req2 = 2'b00; @(negedge clk);
        // Request withdrawn while waiting
        req2 = 2'b10; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        req2 = 2'b00; @(negedge clk);
        mok2 = 1'b1; minst2 = 32'h3333_3333;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b00 || inst2[63:32] !== 32'h1111_1111) begin
            n_err++; $display("FAIL req_withdrawn: ok=%b inst1=%h want 00 11111111", ok2, inst2[63:32]);
        end
        mok2 = 1'b0; @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k;
        // Way0 grant moves the pointer to way1 before the reset hits
        req2 = 2'b01; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (mreq2 !== 1'b1 || gid2 !== 1'b0) begin
            n_err++; $display("FAIL rstmid_grant: mreq=%b gid=%b want 1 0", mreq2, gid2);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ok2, mreq2, gid2, busy2} !== 5'b0 || inst2 !== 64'h0 || maddr2 !== 32'h0) begin
            n_err++; $display("FAIL rstmid_outputs: ctrl=%b inst=%h addr=%h want 0",
                              {ok2, mreq2, gid2, busy2}, inst2, maddr2);
        end
        reset_n = 1'b1; req2 = 2'b00;
        @(negedge clk);
        mok2 = 1'b1; minst2 = 32'h0BAD_0BAD;
        @(negedge clk);
        n_cmp++;
        if (ok2 !== 2'b00 || busy2 !== 1'b0 || mreq2 !== 1'b0 || inst2 !== 64'h0) begin
            n_err++; $display("FAIL rstmid_stale: ok=%b busy=%b mreq=%b inst=%h want 00 0 0 0",
                              ok2, busy2, mreq2, inst2);
        end
        mok2 = 1'b0;
        // Pointer back at 0: way0 wins over way1
        req2 = 2'b11; k = 0;
        while (mreq2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (mreq2 !== 1'b1 || gid2 !== 1'b0 || maddr2 !== A0) begin
            n_err++; $display("FAIL rstmid_ptr: mreq=%b gid=%b addr=%h want 1 0 %h", mreq2, gid2, maddr2, A0);
        end
        mok2 = 1'b1; minst2 = 32'h0000_0055;
        @(negedge clk);
        mok2 = 1'b0; req2 = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fair4();
        int order [6] = '{0, 2, 3, 0, 2, 3};
        int since [4] = '{0, 0, 0, 0};
        req4 = 4'b1101;
        for (int t = 0; t < 6; t++) begin
            int k;
            int e;
            logic [31:0] ea;
            e  = order[t];
            ea = 32'h8000_0000 + (e << 12);
            k  = 0;
            while (mreq4 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            n_cmp++;
            if (mreq4 !== 1'b1 || gid4 !== e[1:0] || maddr4 !== ea) begin
                n_err++; $display("FAIL fair4_grant%0d: mreq=%b gid=%0d addr=%h want 1 %0d %h",
                                  t, mreq4, gid4, maddr4, e, ea);
            end
            for (int w = 0; w < 4; w++) begin
                if (req4[w]) since[w] = (gid4 == w[1:0]) ? 0 : since[w] + 1;
            end
            n_cmp++;
            if (since[0] > 3 || since[2] > 3 || since[3] > 3) begin
                n_err++; $display("FAIL fair4_wait%0d: waits %0d/%0d/%0d want <=3",
                                  t, since[0], since[2], since[3]);
            end
            mok4 = 1'b1; minst4 = 32'h400 + t;
            @(negedge clk);
            n_cmp++;
            if (ok4 !== (4'b0001 << e) || inst4[e*32 +: 32] !== 32'h400 + t) begin
                n_err++; $display("FAIL fair4_resp%0d: ok=%b inst=%h want %b %h",
                                  t, ok4, inst4[e*32 +: 32], 4'b0001 << e, 32'h400 + t);
            end
            mok4 = 1'b0;
            if (t == 5) req4 = 4'b0000;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_reset_mid();
        test_fair4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_arbiter
`default_nettype wire
